feedback_packer: RTL and testbench
==================================

FEEDBACK_PACKER -- requirements
Module: feedback_packer

Interface
REQ-001 SHALL provide parameter WORD_WIDTH, default 16: width of every feedback field, ID and data word.
REQ-002 SHALL provide parameter ADDR_WIDTH, default 16: memory address width.
REQ-003 SHALL provide parameter BATT_BASE, default 328: base address of the battery table.
REQ-004 SHALL provide parameter VALUE_BASE, default 456: base address of the Q-value table.
REQ-005 SHALL provide parameter DEST_BASE, default 72: base address of the neighbour-ID table.
REQ-006 SHALL provide parameter IDLE_ADDR, default 8: address driven while idle.
REQ-007 SHALL provide parameter MEM_LAT, default 1, legal range 0..7: memory read latency in cycles.
REQ-008 SHALL have ports: clock  in  1  rising-edge clock.
REQ-009 SHALL have ports: nreset  in  1  reset; one clock; reset is synchronous and active-low.
REQ-010 SHALL have ports: done_prev  in  1  start; only a 0->1 transition is a request.
REQ-011 SHALL have ports: ack  in  1  consumer acknowledge of a packet.
REQ-012 SHALL have ports: _action, _besthop, MY_NODE_ID, MY_CLUSTER_ID  in  WORD_WIDTH each  packet inputs.
REQ-013 SHALL have ports: address  out  ADDR_WIDTH  memory read address; rd_en  out  1  read strobe.
REQ-014 SHALL have ports: data_in  in  WORD_WIDTH  memory read data.
REQ-015 SHALL have ports: data_out  out  PKT_W  packet; PKT_W = 5*WORD_WIDTH, or 6*WORD_WIDTH with the checksum.
REQ-016 SHALL have ports: done  out  1  packet valid; busy  out  1  FSM not in IDLE.

Function
REQ-017 SHALL detect the start with a registered copy of done_prev; a request is done_prev=1 with the previous sample 0, seen in IDLE only.
REQ-018 SHALL ignore a done_prev rising edge outside IDLE; it SHALL NOT be queued.
REQ-019 SHALL capture _action, _besthop, MY_NODE_ID and MY_CLUSTER_ID on the accepting edge; later changes SHALL NOT affect the packet.
REQ-020 SHALL use FSM states IDLE -> RD_BATT -> RD_VAL -> RD_DEST -> PACK -> DONE -> IDLE.
REQ-021 SHALL hold each RD_* state for exactly MEM_LAT+1 cycles, with rd_en=1 and address stable.
REQ-022 SHALL capture data_in on the edge that leaves each RD_* state.
REQ-023 SHALL form addresses as BATT_BASE+MY_NODE_ID, VALUE_BASE+_besthop and DEST_BASE+_action, each truncated modulo 2^ADDR_WIDTH.
REQ-024 SHALL drive address=IDLE_ADDR and rd_en=0 in IDLE, PACK and DONE.
REQ-025 SHALL register data_out in PACK as {MY_NODE_ID, batt, value, MY_CLUSTER_ID, dest}, MSB first.
REQ-026 SHALL raise done on the edge that enters DONE; latency SHALL be 3*(MEM_LAT+1)+1 edges from the accepting edge.
REQ-027 SHALL hold done=1 and data_out stable in DONE until ack=1; on the edge sampling ack=1 the FSM SHALL go to IDLE with done=0.
REQ-028 SHALL ignore ack outside DONE.
REQ-029 SHALL treat ack=1 together with a done_prev rising edge in DONE as ack only; the start SHALL be dropped.
REQ-030 SHALL keep data_out holding the last packet after DONE until the next PACK.

Reset
REQ-031 SHALL, on any edge with nreset=0 including mid-operation, set state=IDLE, done=0, busy=0, rd_en=0, address=IDLE_ADDR, data_out=0 and the done_prev history=0, abandoning any partial packet.
REQ-032 SHALL NOT react to nreset asynchronously.

Configuration
REQ-033 SHALL support macro FEEDBACK_CHECKSUM_EN.
REQ-034 SHALL, when FEEDBACK_CHECKSUM_EN is defined, make data_out 6*WORD_WIDTH wide, with the lowest word equal to the XOR of the five fields, computed in PACK.
REQ-035 SHALL, when FEEDBACK_CHECKSUM_EN is undefined, make data_out 5*WORD_WIDTH wide with no checksum logic.

Verification
REQ-036 SHALL cover basic packet: MEM_LAT=1, NODE=3, CLUSTER=1, besthop=2, action=5; mem[331]=0x0050, mem[458]=0x1234, mem[77]=0x0007 -> addresses 331,458,77, each held 2 cycles; done at edge 7; data_out=0x0003_0050_1234_0001_0007.
REQ-037 SHALL cover address wrap: ADDR_WIDTH=16, _action=0xFFFF -> dest address 0x0047.
REQ-038 SHALL cover handshake: ack held 0 for 10 cycles -> done and data_out stable; ack=1 -> done=0 and busy=0 next edge.
REQ-039 SHALL cover ignored start: done_prev toggled in RD_VAL -> exactly one packet, no second request after ack.
REQ-040 SHALL cover mid-operation reset: nreset=0 for one edge in RD_DEST -> all outputs at reset values; a new request completes normally.
REQ-041 SHALL cover checksum: with FEEDBACK_CHECKSUM_EN and the REQ-036 inputs -> low word = 0x0003^0x0050^0x1234^0x0001^0x0007 = 0x1261.

Source files
------------

// File: rtl/feedback_packer.sv
`default_nettype none
// ==== feedback_packer: fetches battery, Q-value and neighbour-ID words and packs a feedback packet ====
// ==== Rev 1.0 | optional macro FEEDBACK_CHECKSUM_EN appends an XOR checksum word               ====
module feedback_packer #(
  parameter int WORD_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int BATT_BASE  = 328,
  parameter int VALUE_BASE = 456,
  parameter int DEST_BASE  = 72,
  parameter int IDLE_ADDR  = 8,
  parameter int MEM_LAT    = 1,
`ifdef FEEDBACK_CHECKSUM_EN
  localparam int PKT_W = 6 * WORD_WIDTH
`else
  localparam int PKT_W = 5 * WORD_WIDTH
`endif
) (
  input  logic                  clock,
  input  logic                  nreset,
  input  logic                  done_prev,
  input  logic                  ack,
  input  logic [WORD_WIDTH-1:0] _action,
  input  logic [WORD_WIDTH-1:0] _besthop,
  input  logic [WORD_WIDTH-1:0] MY_NODE_ID,
  input  logic [WORD_WIDTH-1:0] MY_CLUSTER_ID,
  output logic [ADDR_WIDTH-1:0] address,
  output logic                  rd_en,
  input  logic [WORD_WIDTH-1:0] data_in,
  output logic [PKT_W-1:0]      data_out,
  output logic                  done,
  output logic                  busy
);

  localparam logic [2:0]            LAT_LAST   = 3'(MEM_LAT);
  localparam logic [ADDR_WIDTH-1:0] IDLE_A     = ADDR_WIDTH'(IDLE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] BATT_A     = ADDR_WIDTH'(BATT_BASE);
  localparam logic [ADDR_WIDTH-1:0] VALUE_A    = ADDR_WIDTH'(VALUE_BASE);
  localparam logic [ADDR_WIDTH-1:0] DEST_A     = ADDR_WIDTH'(DEST_BASE);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_BATT = 3'd1,
    RD_VAL  = 3'd2,
    RD_DEST = 3'd3,
    PACK    = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t                state;
  logic                  prev_start;
  logic [2:0]            lat_cnt;
  logic [WORD_WIDTH-1:0] node_q, cluster_q, hop_q, action_q;
  logic [WORD_WIDTH-1:0] batt_q, value_q, dest_q;

  // Address sums wrap naturally at ADDR_WIDTH bits.
  logic [ADDR_WIDTH-1:0] batt_addr, value_addr, dest_addr;
  assign batt_addr  = BATT_A  + ADDR_WIDTH'(MY_NODE_ID);
  assign value_addr = VALUE_A + ADDR_WIDTH'(hop_q);
  assign dest_addr  = DEST_A  + ADDR_WIDTH'(action_q);

  logic [PKT_W-1:0] packet;
`ifdef FEEDBACK_CHECKSUM_EN
  assign packet = {node_q, batt_q, value_q, cluster_q, dest_q,
                   node_q ^ batt_q ^ value_q ^ cluster_q ^ dest_q};
`else
  assign packet = {node_q, batt_q, value_q, cluster_q, dest_q};
`endif

  logic lat_done;
  assign lat_done = (lat_cnt == LAT_LAST);

  always_ff @(posedge clock) begin
    if (!nreset) begin
      state      <= IDLE;
      prev_start <= 1'b0;
      lat_cnt    <= 3'd0;
      done       <= 1'b0;
      busy       <= 1'b0;
      rd_en      <= 1'b0;
      address    <= IDLE_A;
      data_out   <= '0;
      node_q     <= '0;
      cluster_q  <= '0;
      hop_q      <= '0;
      action_q   <= '0;
      batt_q     <= '0;
      value_q    <= '0;
      dest_q     <= '0;
    end else begin
      prev_start <= done_prev;
      case (state)
        IDLE: begin
          if (done_prev && !prev_start) begin
            node_q    <= MY_NODE_ID;
            cluster_q <= MY_CLUSTER_ID;
            hop_q     <= _besthop;
            action_q  <= _action;
            state     <= RD_BATT;
            busy      <= 1'b1;
            rd_en     <= 1'b1;
            address   <= batt_addr;
            lat_cnt   <= 3'd0;
          end
        end
        RD_BATT: begin
          if (lat_done) begin
            batt_q  <= data_in;
            state   <= RD_VAL;
            address <= value_addr;
            lat_cnt <= 3'd0;
          end else begin
            lat_cnt <= lat_cnt + 3'd1;
          end
        end
        RD_VAL: begin
          if (lat_done) begin
            value_q <= data_in;
            state   <= RD_DEST;
            address <= dest_addr;
            lat_cnt <= 3'd0;
          end else begin
            lat_cnt <= lat_cnt + 3'd1;
          end
        end
        RD_DEST: begin
          if (lat_done) begin
            dest_q  <= data_in;
            state   <= PACK;
            rd_en   <= 1'b0;
            address <= IDLE_A;
            lat_cnt <= 3'd0;
          end else begin
            lat_cnt <= lat_cnt + 3'd1;
          end
        end
        PACK: begin
          data_out <= packet;
          state    <= DONE;
          done     <= 1'b1;
        end
        DONE: begin
          // A start arriving with ack is deliberately dropped.
          if (ack) begin
            state <= IDLE;
            done  <= 1'b0;
            busy  <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          done    <= 1'b0;
          busy    <= 1'b0;
          rd_en   <= 1'b0;
          address <= IDLE_A;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_feedback_packer.sv
`default_nettype none
// ==== tb_feedback_packer: randomized packets against a table-level reference model ====
// ==== Rev 1.0                                                                        ====
module tb_feedback_packer;

  localparam int LAT = 1;
`ifdef FEEDBACK_CHECKSUM_EN
  localparam int PKT_W = 96;
  localparam logic [127:0] BASIC = 128'h0003_0050_1234_0001_0007_1261;
`else
  localparam int PKT_W = 80;
  localparam logic [127:0] BASIC = 128'h0003_0050_1234_0001_0007;
`endif

  logic             clock = 1'b0;
  logic             nreset;
  logic             done_prev;
  logic             ack;
  logic [15:0]      action, besthop, node_id, cluster_id;
  logic [15:0]      address;
  logic             rd_en;
  logic [15:0]      data_in;
  logic [PKT_W-1:0] data_out;
  logic             done;
  logic             busy;

  logic [15:0] mem [0:65535];
  int passed = 0;
  int total  = 0;

  feedback_packer dut (
    .clock         (clock),
    .nreset        (nreset),
    .done_prev     (done_prev),
    .ack           (ack),
    ._action       (action),
    ._besthop      (besthop),
    .MY_NODE_ID    (node_id),
    .MY_CLUSTER_ID (cluster_id),
    .address       (address),
    .rd_en         (rd_en),
    .data_in       (data_in),
    .data_out      (data_out),
    .done          (done),
    .busy          (busy)
  );

  always #5 clock = ~clock;

  // One-cycle read latency memory.
  always @(posedge clock) data_in <= mem[address];

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  function automatic logic [15:0] addr_of(input int base, input logic [15:0] idx);
    return 16'((base + int'(idx)) % 65536);
  endfunction

  function automatic logic [127:0] model_pkt(input logic [15:0] n, c, h, a);
    logic [15:0] b, v, d;
    b = mem[addr_of(328, n)];
    v = mem[addr_of(456, h)];
    d = mem[addr_of(72, a)];
`ifdef FEEDBACK_CHECKSUM_EN
    return {32'b0, n, b, v, c, d, n ^ b ^ v ^ c ^ d};
`else
    return {48'b0, n, b, v, c, d};
`endif
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Issues one request and follows it through to the DONE state.
  task automatic send(input logic [15:0] n, c, h, a, input bit dup_start,
                      input bit early_ack, output logic [127:0] exp);
    logic [15:0] ea [3];
    ea[0] = addr_of(328, n);
    ea[1] = addr_of(456, h);
    ea[2] = addr_of(72, a);
    exp   = model_pkt(n, c, h, a);
    @(negedge clock); done_prev = 1'b0;
    @(negedge clock);
    node_id = n; cluster_id = c; besthop = h; action = a; done_prev = 1'b1;
    for (int k = 0; k <= 3 * (LAT + 1) + 1; k++) begin
      @(posedge clock); #1;
      if (k < 3 * (LAT + 1)) begin
        check("rd_addr", address, ea[k / (LAT + 1)]);
        check("rd_en", rd_en, 1);
        check("rd_busy", busy, 1);
        check("rd_done", done, 0);
      end else if (k == 3 * (LAT + 1)) begin
        check("pack_rd_en", rd_en, 0);
        check("pack_addr", address, 16'd8);
        check("pack_done", done, 0);
      end else begin
        check("done_latency", done, 1);
        check("data_out", data_out, exp);
      end
      @(negedge clock);
      if (k == 0) begin
        node_id = 16'($urandom); cluster_id = 16'($urandom);
        besthop = 16'($urandom); action = 16'($urandom);
      end
      if (early_ack) ack = (k == 0);
      if (dup_start && k == LAT + 1) done_prev = 1'b0;
      if (dup_start && k == 2 * LAT + 1) done_prev = 1'b1;
    end
  endtask

  // Holds in DONE, acknowledges, then confirms the block stays idle.
  task automatic finish_pkt(input logic [127:0] exp, input int hold, input bit start_with_ack);
    for (int i = 0; i < hold; i++) begin
      done_prev = 1'b0;
      @(posedge clock); #1;
      check("hold_done", done, 1);
      check("hold_data", data_out, exp);
      @(negedge clock);
    end
    ack = 1'b1;
    if (start_with_ack) done_prev = 1'b1;
    @(posedge clock); #1;
    check("ack_done", done, 0);
    check("ack_busy", busy, 0);
    @(negedge clock); ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      check("idle_busy", busy, 0);
      check("idle_rd_en", rd_en, 0);
      check("idle_addr", address, 16'd8);
      check("last_pkt_kept", data_out, exp);
      @(negedge clock);
    end
  endtask

  initial begin
    logic [127:0] exp;
    logic [15:0]  n, c, h, a;
    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
    mem[331] = 16'h0050;
    mem[458] = 16'h1234;
    mem[77]  = 16'h0007;
    nreset = 1'b0; done_prev = 1'b0; ack = 1'b0;
    action = '0; besthop = '0; node_id = '0; cluster_id = '0;

    repeat (3) @(posedge clock);
    #1;
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_rd_en", rd_en, 0);
    check("rst_addr", address, 16'd8);
    check("rst_data", data_out, 0);
    @(negedge clock); nreset = 1'b1;

    // Reference packet with a long handshake hold.
    send(16'd3, 16'd1, 16'd2, 16'd5, 1'b0, 1'b0, exp);
    check("basic_pkt", data_out, BASIC);
    finish_pkt(exp, 10, 1'b0);

    // Start arriving in RD_VAL must not spawn a second packet.
    send(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 1'b1, 1'b0, exp);
    finish_pkt(exp, 1, 1'b0);

    // Ack outside DONE is ignored; a start together with ack is dropped.
    send(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 1'b0, 1'b1, exp);
    finish_pkt(exp, 2, 1'b1);

    for (int r = 0; r < 12; r++) begin
      send(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
           1'b0, 1'($urandom), exp);
      finish_pkt(exp, int'($urandom_range(1, 4)), 1'($urandom));
    end

    // Reset while in RD_DEST, with the destination address wrapping.
    @(negedge clock); done_prev = 1'b0;
    @(negedge clock);
    node_id = 16'd9; cluster_id = 16'd4; besthop = 16'd1; action = 16'hFFFF; done_prev = 1'b1;
    repeat (2 * (LAT + 1) + 1) @(posedge clock);
    #1;
    check("wrap_addr", address, 16'h0047);
    @(negedge clock); nreset = 1'b0; done_prev = 1'b0;
    @(posedge clock); #1;
    check("mid_rst_done", done, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_rd_en", rd_en, 0);
    check("mid_rst_addr", address, 16'd8);
    check("mid_rst_data", data_out, 0);
    @(negedge clock); nreset = 1'b1;
    n = 16'($urandom); c = 16'($urandom); h = 16'($urandom); a = 16'($urandom);
    send(n, c, h, a, 1'b0, 1'b0, exp);
    finish_pkt(exp, 3, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
